// File: rtl/spi_master_ram_host.sv
// spi_master_ram_host: host-side SPI initiator issuing one {cmd,payload} frame per request,
// capturing the reply byte on MISO for RD_DATA.
module spi_master_ram_host #(
  parameter int MEM_WIDTH = 8,
  parameter int RD_GAP    = 2,
  parameter int IDLE_GAP  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_cmd,
  input  logic [MEM_WIDTH-1:0] req_data,
  output logic                 rsp_valid,
  output logic [MEM_WIDTH-1:0] rsp_data,
  output logic                 busy,
  output logic                 SS_n,
  output logic                 MOSI,
  input  logic                 MISO
);
  localparam int FW = MEM_WIDTH + 2;
  localparam int CW = (FW > 16) ? $clog2(FW) : 4;
  typedef enum logic [2:0] {IDLE, SEL, CMD, SHIFT, WAIT, CAPT, GAP} state_t;
  state_t               state, nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [FW-1:0]        frame;
  logic [MEM_WIDTH-1:0] sh;
  logic                 take, sel_nxt, mosi_nxt, is_rd, last_capt;
  assign take      = req_valid && req_ready;
  assign is_rd     = &frame[FW-1 -: 2];
  assign last_capt = (state == CAPT) && (cnt == '0);
  assign sel_nxt   = (nxt != IDLE) && (nxt != GAP);
  assign mosi_nxt  = (nxt == CMD) ? frame[FW-1] : (nxt == SHIFT) ? frame[cnt_nxt] : 1'b0;
  always_comb begin
    nxt     = state;
    cnt_nxt = cnt - 1'b1;
    case (state)
      IDLE:    nxt = take ? SEL : IDLE;
      SEL:     nxt = CMD;
      CMD: begin
        nxt     = SHIFT;
        cnt_nxt = CW'(FW - 1);
      end
      SHIFT:
        if (cnt == '0) begin
          nxt     = is_rd ? WAIT : GAP;
          cnt_nxt = is_rd ? CW'(RD_GAP - 1) : CW'(IDLE_GAP - 1);
        end
      WAIT:
        if (cnt == '0) begin
          nxt     = CAPT;
          cnt_nxt = CW'(MEM_WIDTH - 1);
        end
      CAPT:
        if (cnt == '0) begin
          nxt     = GAP;
          cnt_nxt = CW'(IDLE_GAP - 1);
        end
      GAP:     nxt = (cnt == '0) ? IDLE : GAP;
      default: nxt = IDLE;
    endcase
  end
  // outputs are registered from the next state so they line up with the state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      frame     <= '0;
      sh        <= '0;
      SS_n      <= 1'b1;
      MOSI      <= 1'b0;
      req_ready <= 1'b0;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      state     <= nxt;
      cnt       <= cnt_nxt;
      SS_n      <= !sel_nxt;
      busy      <= sel_nxt;
      MOSI      <= mosi_nxt;
      req_ready <= (nxt == IDLE);
      rsp_valid <= last_capt;
      if (take) frame <= {req_cmd, req_data};
      if (state == CAPT) sh <= {sh[MEM_WIDTH-2:0], MISO};
      if (last_capt) rsp_data <= {sh[MEM_WIDTH-2:0], MISO};
    end
  end
endmodule
